// File: rtl/inert_intf_fsm.sv
// Inertial sensor front end: configures the sensor over the SPI master, then on each
// data-ready interrupt reads eight byte registers and presents four signed 16-bit samples.
module inert_intf_fsm #(
  parameter int unsigned INIT_WAIT_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rspns,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] roll_rt,
  output logic [15:0] yaw_rt,
  output logic [15:0] AY,
  output logic [15:0] AZ
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned N_SHADOW = 7;

  typedef enum logic [1:0] {
    INIT_WAIT = 2'd0,
    CFG       = 2'd1,
    WAIT_INT  = 2'd2,
    RD        = 2'd3
  } state_t;

  state_t                    state_q;
  logic [INIT_WAIT_BITS-1:0] wait_cnt_q;
  logic                      int_ff1_q;
  logic                      int_ff2_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      busy_q;
  logic                      wrt_q;
  logic [15:0]               cmd_q;
  logic                      vld_q;
  logic [15:0]               roll_q;
  logic [15:0]               yaw_q;
  logic [15:0]               ay_q;
  logic [15:0]               az_q;
  // The last byte (0xAD) goes straight from rspns into AZ, so only seven shadows are kept.
  logic [7:0]                shadow_q [N_SHADOW];

  logic unused_rspns_hi;
  assign unused_rspns_hi = &{1'b0, rspns[15:8]};

  function automatic logic [15:0] cfg_cmd(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    cfg_cmd = 16'h0D02;
      3'd1:    cfg_cmd = 16'h1053;
      3'd2:    cfg_cmd = 16'h1150;
      default: cfg_cmd = 16'h1460;
    endcase
  endfunction

  // Read command high byte is {R=1, addr[6:0]}.
  function automatic logic [7:0] rd_hi(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    rd_hi = 8'hA4;
      3'd1:    rd_hi = 8'hA5;
      3'd2:    rd_hi = 8'hA6;
      3'd3:    rd_hi = 8'hA7;
      3'd4:    rd_hi = 8'hAA;
      3'd5:    rd_hi = 8'hAB;
      3'd6:    rd_hi = 8'hAC;
      default: rd_hi = 8'hAD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_WAIT;
      wait_cnt_q <= '0;
      int_ff1_q  <= 1'b0;
      int_ff2_q  <= 1'b0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h0000;
      vld_q      <= 1'b0;
      roll_q     <= 16'h0000;
      yaw_q      <= 16'h0000;
      ay_q       <= 16'h0000;
      az_q       <= 16'h0000;
      for (int i = 0; i < N_SHADOW; i++) shadow_q[i] <= 8'h00;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      wrt_q     <= 1'b0;
      vld_q     <= 1'b0;
      case (state_q)
        INIT_WAIT: begin
          wait_cnt_q <= wait_cnt_q + INIT_WAIT_BITS'(1);
          if (&wait_cnt_q) begin
            state_q <= CFG;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        CFG: begin
          if (!busy_q) begin
            wrt_q  <= 1'b1;
            cmd_q  <= cfg_cmd(idx_q);
            busy_q <= 1'b1;
          end else if (done) begin
            busy_q <= 1'b0;
            if (idx_q == IDX_W'(3)) begin
              idx_q   <= '0;
              state_q <= WAIT_INT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        WAIT_INT: begin
          if (int_ff2_q) begin
            state_q <= RD;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        RD: begin
          if (!busy_q) begin
            wrt_q  <= 1'b1;
            cmd_q  <= {rd_hi(idx_q), 8'h00};
            busy_q <= 1'b1;
          end else if (done) begin
            busy_q <= 1'b0;
            if (idx_q == IDX_W'(7)) begin
              roll_q  <= {shadow_q[1], shadow_q[0]};
              yaw_q   <= {shadow_q[3], shadow_q[2]};
              ay_q    <= {shadow_q[5], shadow_q[4]};
              az_q    <= {rspns[7:0], shadow_q[6]};
              vld_q   <= 1'b1;
              idx_q   <= '0;
              state_q <= WAIT_INT;
            end else begin
              shadow_q[idx_q] <= rspns[7:0];
              idx_q           <= idx_q + IDX_W'(1);
            end
          end
        end
        default: state_q <= INIT_WAIT;
      endcase
    end
  end

  assign wrt     = wrt_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign roll_rt = roll_q;
  assign yaw_rt  = yaw_q;
  assign AY      = ay_q;
  assign AZ      = az_q;

endmodule

// File: tb/tb_inert_intf_fsm.sv
// Bench for inert_intf_fsm: SPI slave model with fixed 5-cycle done latency, queue
// scoreboard for commands and sample sets, continuous output-hold checking.
module tb_inert_intf_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rspns;
  logic        wrt;
  logic [15:0] cmd;
  logic        vld;
  logic [15:0] roll_rt, yaw_rt, AY, AZ;

  inert_intf_fsm #(.INIT_WAIT_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rspns(rspns),
    .wrt(wrt), .cmd(cmd), .vld(vld),
    .roll_rt(roll_rt), .yaw_rt(yaw_rt), .AY(AY), .AZ(AZ)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wrt_cnt = 0;
  int vld_cnt = 0;
  int inj_req = 0;
  int inj_ack = 0;

  logic [15:0] exp_cmd_q [$];
  logic [63:0] exp_out_q [$];
  logic [7:0]  resp_tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int addr_idx(input logic [7:0] a);
    case (a)
      8'hA4: return 0;
      8'hA5: return 1;
      8'hA6: return 2;
      8'hA7: return 3;
      8'hAA: return 4;
      8'hAB: return 5;
      8'hAC: return 6;
      8'hAD: return 7;
      default: return -1;
    endcase
  endfunction

  // SPI slave model: done 5 cycles after each wrt, plus on-demand stray done pulses.
  initial begin
    int          delay;
    bit          pending;
    logic [7:0]  hi;
    int          k;
    pending = 0;
    delay = 0;
    hi = 8'h00;
    done = 1'b0;
    rspns = 16'h0000;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_n) begin
        pending = 0;
      end else begin
        if (inj_req != inj_ack) begin
          done = 1'b1;
          rspns = 16'h1111;
          inj_ack++;
        end else if (pending) begin
          delay--;
          if (delay == 0) begin
            pending = 0;
            done = 1'b1;
            k = addr_idx(hi);
            rspns = (k < 0) ? 16'h0000 : {8'hEE, resp_tbl[k]};
          end
        end
        if (wrt) begin
          pending = 1;
          delay = 5;
          hi = cmd[15:8];
        end
      end
    end
  end

  // Monitor: pops expectations on wrt/vld and checks output hold every other cycle.
  initial begin
    int          cyc;
    bit          outstanding;
    bit          prev_wrt, prev_vld;
    logic [63:0] held, e;
    cyc = 0;
    outstanding = 0;
    prev_wrt = 0;
    prev_vld = 0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        cyc = 0;
        outstanding = 0;
        prev_wrt = 0;
        prev_vld = 0;
        held = '0;
      end else begin
        cyc++;
        if (wrt) begin
          chk("wrt_one_cycle", 64'(prev_wrt), 64'd0);
          chk("wrt_before_done", 64'(outstanding), 64'd0);
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wrt: got cmd %h expected no wrt at %0t", cmd, $time);
          end else begin
            e = 64'(exp_cmd_q.pop_front());
            chk("cmd", 64'(cmd), e);
          end
          if (cmd == 16'h0D02) chk("init_wait_len", 64'(cyc > 16), 64'd1);
          outstanding = 1;
          wrt_cnt++;
        end else if (done && outstanding) begin
          outstanding = 0;
        end
        if (vld) begin
          chk("vld_one_cycle", 64'(prev_vld), 64'd0);
          if (exp_out_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vld: got %h expected no vld at %0t",
                     {roll_rt, yaw_rt, AY, AZ}, $time);
          end else begin
            held = exp_out_q.pop_front();
            chk("sample_set", {roll_rt, yaw_rt, AY, AZ}, held);
          end
          vld_cnt++;
        end else begin
          chk("outputs_hold", {roll_rt, yaw_rt, AY, AZ}, held);
        end
        prev_wrt = wrt;
        prev_vld = vld;
      end
    end
  end

  task automatic push_cfg();
    exp_cmd_q.push_back(16'h0D02);
    exp_cmd_q.push_back(16'h1053);
    exp_cmd_q.push_back(16'h1150);
    exp_cmd_q.push_back(16'h1460);
  endtask

  task automatic push_reads();
    exp_cmd_q.push_back(16'hA400);
    exp_cmd_q.push_back(16'hA500);
    exp_cmd_q.push_back(16'hA600);
    exp_cmd_q.push_back(16'hA700);
    exp_cmd_q.push_back(16'hAA00);
    exp_cmd_q.push_back(16'hAB00);
    exp_cmd_q.push_back(16'hAC00);
    exp_cmd_q.push_back(16'hAD00);
  endtask

  // bytes packed A4,A5,A6,A7,AA,AB,AC,AD from MSB down
  task automatic load_set(input logic [63:0] bytes);
    for (int i = 0; i < 8; i++) resp_tbl[i] = bytes[63-8*i -: 8];
  endtask

  task automatic wait_wrt(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (wrt_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (wrt_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d wrt expected %0d (timeout)", name, wrt_cnt, target);
    end
  endtask

  task automatic wait_vld(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (vld_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (vld_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d vld expected %0d (timeout)", name, vld_cnt, target);
    end
  endtask

  task automatic pulse_int(input int len);
    INT = 1'b1;
    repeat (len) @(negedge clk);
    INT = 1'b0;
  endtask

  initial begin
    int base, vbase;
    rst_n = 1'b0;
    INT = 1'b0;
    for (int i = 0; i < 8; i++) resp_tbl[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wrt", 64'(wrt), 64'd0);
    chk("rst_vld", 64'(vld), 64'd0);
    chk("rst_cmd", 64'(cmd), 64'd0);
    chk("rst_roll", 64'(roll_rt), 64'd0);
    chk("rst_yaw", 64'(yaw_rt), 64'd0);
    chk("rst_ay", 64'(AY), 64'd0);
    chk("rst_az", 64'(AZ), 64'd0);

    // Power-up and configuration
    push_cfg();
    rst_n = 1'b1;
    wait_wrt(4, 300, "cfg_writes");
    repeat (20) @(negedge clk);

    // Single interrupt, mixed-sign data
    load_set(64'h34_12_CD_AB_00_80_FF_7F);
    push_reads();
    exp_out_q.push_back(64'h1234_ABCD_8000_7FFF);
    pulse_int(3);
    wait_vld(1, 400, "single_seq");
    repeat (30) @(negedge clk);

    // INT held high: back-to-back sequences; INT drops during the 2nd vld cycle,
    // which is too late to stop the 3rd sequence from starting.
    load_set(64'h01_80_FF_FF_55_AA_00_00);
    for (int i = 0; i < 3; i++) begin
      push_reads();
      exp_out_q.push_back(64'h8001_FFFF_AA55_0000);
    end
    vbase = vld_cnt;
    INT = 1'b1;
    wait_vld(vbase + 2, 800, "held_int_2");
    INT = 1'b0;
    wait_vld(vbase + 3, 400, "held_int_3");
    repeat (40) @(negedge clk);

    // INT toggled mid-read: no restart, no extra vld
    load_set(64'h5A_C3_00_01_FE_FF_80_00);
    push_reads();
    exp_out_q.push_back(64'hC35A_0100_FFFE_0080);
    base = wrt_cnt;
    vbase = vld_cnt;
    pulse_int(3);
    wait_wrt(base + 3, 200, "toggle_reads");
    pulse_int(3);
    repeat (2) @(negedge clk);
    pulse_int(2);
    wait_vld(vbase + 1, 400, "toggle_seq");
    repeat (60) @(negedge clk);
    chk("toggle_vld_count", 64'(vld_cnt), 64'(vbase + 1));

    // Stray done pulses while waiting for INT
    base = wrt_cnt;
    vbase = vld_cnt;
    for (int i = 0; i < 3; i++) begin
      inj_req++;
      repeat (5) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("stray_done_wrt", 64'(wrt_cnt), 64'(base));
    chk("stray_done_vld", 64'(vld_cnt), 64'(vbase));

    // Reset after the 3rd read's wrt, stray done after release
    load_set(64'h34_12_CD_AB_00_80_FF_7F);
    push_reads();
    base = wrt_cnt;
    pulse_int(3);
    wait_wrt(base + 3, 200, "pre_reset_reads");
    @(negedge clk);
    rst_n = 1'b0;
    exp_cmd_q.delete();
    exp_out_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_vld", 64'(vld), 64'd0);
    chk("mid_rst_outs", {roll_rt, yaw_rt, AY, AZ}, 64'd0);
    chk("mid_rst_wrt", 64'(wrt), 64'd0);
    push_cfg();
    base = wrt_cnt;
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    inj_req++;
    wait_wrt(base + 4, 300, "recfg_writes");
    repeat (30) @(negedge clk);
    chk("post_rst_outs", {roll_rt, yaw_rt, AY, AZ}, 64'd0);

    chk("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    chk("out_queue_empty", 64'(exp_out_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
